// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern driver: mode select values and the
// scan-direction state used by the bouncing-scan pattern.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ALL_ON = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    typedef enum logic {
        SCAN_UP   = 1'b0,
        SCAN_DOWN = 1'b1
    } scan_dir_e;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with a duty comparator; an all-ones level
// forces the output permanently on so full brightness has no dark slot.
module led_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] level,
    output logic                on
);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + PWM_BITS'(1);
    end

    assign on = (cnt < level) || (level == {PWM_BITS{1'b1}});

endmodule

// File: rtl/led_pattern_driver.sv
// Pattern source (all-on / scan / count / off) plus PWM dimming for the user LEDs.
// Optional SCAN fade trail is built when LED_PATTERN_FADE_EN is defined.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS    = 7,
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 3_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] led,
    output logic                step
);

    localparam int                  CNT_W    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [NUM_LEDS-1:0] PAT_ONES = {NUM_LEDS{1'b1}};
    localparam logic [NUM_LEDS-1:0] PAT_LSB  = NUM_LEDS'(1);

    mode_e               mode_q;
    logic                chg;
    logic [CNT_W-1:0]    step_cnt;
    logic [CNT_W-1:0]    step_cnt_nxt;
    logic [NUM_LEDS-1:0] pat;
    scan_dir_e           dir;
    logic                pwm_on;

    // Step timer; a registered mode change restarts it so the first step of
    // a new pattern always comes a full STEP_CYCLES after the reload.
    always_comb begin
        step_cnt_nxt = step_cnt + CNT_W'(1);
        if (chg || step_cnt == CNT_LAST) step_cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            step     <= 1'b0;
        end else begin
            step_cnt <= step_cnt_nxt;
            step     <= (step_cnt_nxt == CNT_LAST);
        end
    end

    // Mode tracking, reload and pattern advance; a pending reload
    // takes priority over a coincident step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            chg    <= 1'b0;
            pat    <= '0;
            dir    <= SCAN_UP;
        end else begin
            mode_q <= mode_e'(mode);
            chg    <= (mode != mode_q);
            if (chg) begin
                case (mode_q)
                    MODE_SCAN: begin
                        pat <= PAT_LSB;
                        dir <= SCAN_UP;
                    end
                    MODE_ALL_ON: pat <= PAT_ONES;
                    default:     pat <= '0;
                endcase
            end else begin
                case (mode_q)
                    MODE_ALL_ON: pat <= PAT_ONES;
                    MODE_OFF:    pat <= '0;
                    MODE_COUNT: begin
                        if (step) pat <= pat + NUM_LEDS'(1);
                    end
                    MODE_SCAN: begin
                        if (step) begin
                            if (dir == SCAN_UP) begin
                                pat <= pat << 1;
                                if (pat[NUM_LEDS-2]) dir <= SCAN_DOWN;
                            end else begin
                                pat <= pat >> 1;
                                if (pat[1]) dir <= SCAN_UP;
                            end
                        end
                    end
                    default: pat <= '0;
                endcase
            end
        end
    end

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk   (clk),
        .rst   (rst),
        .level (brightness),
        .on    (pwm_on)
    );

`ifdef LED_PATTERN_FADE_EN
    logic [NUM_LEDS-1:0] trail;
    logic                trail_on;

    // Trail remembers the previously lit scan LED, shown at quarter duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                trail <= '0;
        else if (chg)                           trail <= '0;
        else if (mode_q == MODE_SCAN && step)   trail <= pat;
    end

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_trail (
        .clk   (clk),
        .rst   (rst),
        .level (brightness >> 2),
        .on    (trail_on)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= '0;
        else     led <= (pat & {NUM_LEDS{pwm_on}}) | (trail & {NUM_LEDS{trail_on}});
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= '0;
        else     led <= pwm_on ? pat : '0;
    end
`endif

endmodule
